stopwatch_ctrl: RTL
===================

# stopwatch_ctrl

Control FSM for the stopwatch. It sequences the timebase produced by the frequency divider. It debounces the start/stop, lap and clear push-buttons, gates the 1 ms tick into the time counters, issues counter clears, and freezes the 7-segment display for lap readout. It sits between the board buttons, the divider's millisecond output and the BCD time counters.

## Interface
Parameters:
- DB_TICKS, 20: debounce interval, counted in millisecond ticks.
- SYNC_STAGES, 2: synchronizer depth for all asynchronous inputs (minimum 2).

Ports:
- clk, in, 1: 50 MHz system clock.
- rst, in, 1: asynchronous, active-high reset.
- tick_in, in, 1: 1 ms-period square wave from the divider. Each rising edge is one tick.
- btn_ss, in, 1: raw start/stop button, active-high.
- btn_lap, in, 1: raw lap button, active-high.
- btn_clr, in, 1: raw clear button, active-high.
- cnt_tick, out, 1: one-clk pulse per accepted tick, sent to the time counters.
- cnt_clr, out, 1: one-clk clear pulse to the time counters.
- disp_freeze, out, 1: level. While high, the display holds its latched value.
- running, out, 1: high in RUN and LAP_RUN.
- state, out, 3: current FSM state, for debug LEDs.

## Operation
- Reset values: state = IDLE (0), and cnt_tick, cnt_clr, disp_freeze and running are all 0. Synchronizers, debounce counters and stable levels are cleared to 0.
- Tick path:
  - tick_in passes through SYNC_STAGES flops, then a rising-edge detect.
  - The edge produces cnt_tick only if the registered state is RUN or LAP_RUN in the detect cycle.
- Debounce (one per button):
  - The synchronized level is compared with the stable level.
  - While they differ, a counter advances on each tick edge. When it reaches DB_TICKS, the stable level flips and the counter clears.
  - The counter clears whenever the two levels are equal.
  - A press event is a one-clk pulse on a stable 0→1 transition. Release produces no event.
- Event priority within one cycle: clr > ss > lap. Only the highest-priority event is acted on; the others are dropped.
- FSM states: IDLE=0, RUN=1, PAUSE=2, LAP_RUN=3, LAP_PAUSE=4. Encodings 5–7 are illegal and go to IDLE on the next clk.
  - IDLE: ss→RUN. clr→IDLE with a cnt_clr pulse. lap is ignored.
  - RUN: ss→PAUSE. lap→LAP_RUN. clr is ignored.
  - PAUSE: ss→RUN. clr→IDLE with a cnt_clr pulse. lap is ignored.
  - LAP_RUN: lap→RUN. ss→LAP_PAUSE. clr is ignored.
  - LAP_PAUSE: lap→PAUSE. ss→LAP_RUN. clr→IDLE with a cnt_clr pulse.
- Output decoding (all outputs registered):
  - disp_freeze = 1 in LAP_RUN and LAP_PAUSE.
  - running = 1 in RUN and LAP_RUN.
  - cnt_tick is forced to 0 in any cycle where cnt_clr = 1.

## Timing
- Tick latency: cnt_tick rises SYNC_STAGES+1 clk edges after the first clk edge that samples tick_in high. Width is exactly 1 clk. At most one cnt_tick is produced per tick_in period.
- Button latency:
  - A press is held stable for DB_TICKS tick edges, then the press event fires.
  - The state register updates 1 clk after the event.
  - cnt_clr, disp_freeze and running update in the same edge as the state.
- Tick during a transition: gating uses the old state. A tick in the same cycle as RUN→PAUSE is counted. A tick in the same cycle as PAUSE→RUN is not counted.
- Bounce shorter than DB_TICKS ticks produces no event. A button held indefinitely produces exactly one event.
- Button held through reset release: after DB_TICKS ticks, one press event is produced. This is intended behaviour.
- Reset mid-debounce or mid-operation: rst takes effect asynchronously. The pending debounce is discarded, the FSM goes to IDLE, and no cnt_clr is issued. The counters own their own rst.
- If tick_in stops, debounce stalls and no events occur. The FSM holds its state.

## Structure
- Shared package stopwatch_pkg:
  - state encoding constants (IDLE…LAP_PAUSE) and a 3-bit state typedef;
  - the DB_TICKS default;
  - the SYNC_STAGES default.
- Sub-module btn_debounce, instantiated 3×:
  - inputs: clk, rst, raw, tick_edge;
  - outputs: press pulse, stable level.
- The tick synchronizer and edge detect live in the top level and are shared by all debouncers.

## Test plan
All scenarios use DB_TICKS=2 and a tick_in period of 100 clk.
- Reset: assert rst mid-run → all outputs 0 immediately and state=0. After release, no cnt_tick until ss is pressed.
- Start/stop: press ss for 3 ticks → state=1 and running=1. Count 10 cnt_tick. Press ss → state=2, and cnt_tick stays 0 for 5 tick periods.
- Lap:
  - In RUN, press lap → state=3 and disp_freeze=1, with cnt_tick still pulsing.
  - Press ss → state=4.
  - Press lap → state=2 and disp_freeze=0.
- Clear: from PAUSE, press clr → exactly one 1-clk cnt_clr, state=0. Press clr in RUN → ignored, no cnt_clr.
- Bounce and priority:
  - Toggle btn_ss every 30 clk for 500 clk → no event.
  - Press clr and ss simultaneously in PAUSE → state=0 with a cnt_clr pulse; ss is dropped.
- Tick boundary: align the ss press event with a tick edge in RUN → that tick is counted (total 1 cnt_tick in that cycle), then state=2.

Source files
------------

// File: rtl/stopwatch_pkg.sv
//------------------------------------------------------------------------------
// stopwatch_pkg : state encoding and parameter defaults for the stopwatch
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package stopwatch_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_RUN       = 3'd1,
        S_PAUSE     = 3'd2,
        S_LAP_RUN   = 3'd3,
        S_LAP_PAUSE = 3'd4
    } state_t;

    localparam int DB_TICKS_DEFAULT    = 20;
    localparam int SYNC_STAGES_DEFAULT = 2;

endpackage

`default_nettype wire

// File: rtl/stopwatch_ctrl_debounce.sv
//------------------------------------------------------------------------------
// btn_debounce : synchronizes one raw button, debounces it on tick edges and
//                emits a one-clk press pulse on each stable 0->1 transition
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module btn_debounce
    import stopwatch_pkg::*;
#(
    parameter int DB_TICKS    = DB_TICKS_DEFAULT,
    parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    input  logic tick_edge,
    output logic press,
    output logic stable
);

    localparam int CW = $clog2(DB_TICKS + 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   stable_q, stable_d;
    logic                   press_q;

    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        if (sync_q[SYNC_STAGES-1] == stable_q) begin
            cnt_d = '0;
        end else if (tick_edge) begin
            // Flip on the DB_TICKS-th tick edge seen with a differing level.
            if (cnt_q == CW'(DB_TICKS - 1)) begin
                stable_d = ~stable_q;
                cnt_d    = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q   <= '0;
            cnt_q    <= '0;
            stable_q <= 1'b0;
            press_q  <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], raw};
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            press_q  <= stable_d & ~stable_q;
        end
    end

    assign press  = press_q;
    assign stable = stable_q;

endmodule

`default_nettype wire

// File: rtl/stopwatch_ctrl.sv
//------------------------------------------------------------------------------
// stopwatch_ctrl : button/tick control FSM driving the BCD time counters
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int DB_TICKS    = DB_TICKS_DEFAULT,
    parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_in,
    input  logic       btn_ss,
    input  logic       btn_lap,
    input  logic       btn_clr,
    output logic       cnt_tick,
    output logic       cnt_clr,
    output logic       disp_freeze,
    output logic       running,
    output logic [2:0] state
);

    logic [SYNC_STAGES-1:0] tick_sync_q;
    logic                   tick_prev_q;
    logic                   tick_edge;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_sync_q <= '0;
            tick_prev_q <= 1'b0;
        end else begin
            tick_sync_q <= {tick_sync_q[SYNC_STAGES-2:0], tick_in};
            tick_prev_q <= tick_sync_q[SYNC_STAGES-1];
        end
    end

    assign tick_edge = tick_sync_q[SYNC_STAGES-1] & ~tick_prev_q;

    logic       press_ss, press_lap, press_clr;
    logic [2:0] btn_stable_unused;

    btn_debounce #(.DB_TICKS(DB_TICKS), .SYNC_STAGES(SYNC_STAGES)) u_db_ss (
        .clk       (clk),
        .rst       (rst),
        .raw       (btn_ss),
        .tick_edge (tick_edge),
        .press     (press_ss),
        .stable    (btn_stable_unused[0])
    );

    btn_debounce #(.DB_TICKS(DB_TICKS), .SYNC_STAGES(SYNC_STAGES)) u_db_lap (
        .clk       (clk),
        .rst       (rst),
        .raw       (btn_lap),
        .tick_edge (tick_edge),
        .press     (press_lap),
        .stable    (btn_stable_unused[1])
    );

    btn_debounce #(.DB_TICKS(DB_TICKS), .SYNC_STAGES(SYNC_STAGES)) u_db_clr (
        .clk       (clk),
        .rst       (rst),
        .raw       (btn_clr),
        .tick_edge (tick_edge),
        .press     (press_clr),
        .stable    (btn_stable_unused[2])
    );

    // Only the highest-priority event survives, even if the state ignores it.
    logic ev_clr, ev_ss, ev_lap;
    assign ev_clr = press_clr;
    assign ev_ss  = press_ss & ~press_clr;
    assign ev_lap = press_lap & ~press_ss & ~press_clr;

    state_t state_q, state_d;
    logic   cnt_clr_q, cnt_clr_d;
    logic   cnt_tick_q, cnt_tick_d;
    logic   freeze_q, freeze_d;
    logic   running_q, running_d;

    always_comb begin
        state_d   = state_q;
        cnt_clr_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (ev_clr)     cnt_clr_d = 1'b1;
                else if (ev_ss) state_d   = S_RUN;
            end
            S_RUN: begin
                if (ev_ss)       state_d = S_PAUSE;
                else if (ev_lap) state_d = S_LAP_RUN;
            end
            S_PAUSE: begin
                if (ev_clr) begin
                    state_d   = S_IDLE;
                    cnt_clr_d = 1'b1;
                end else if (ev_ss) begin
                    state_d = S_RUN;
                end
            end
            S_LAP_RUN: begin
                if (ev_ss)       state_d = S_LAP_PAUSE;
                else if (ev_lap) state_d = S_RUN;
            end
            S_LAP_PAUSE: begin
                if (ev_clr) begin
                    state_d   = S_IDLE;
                    cnt_clr_d = 1'b1;
                end else if (ev_ss) begin
                    state_d = S_LAP_RUN;
                end else if (ev_lap) begin
                    state_d = S_PAUSE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        running_d  = (state_d == S_RUN) || (state_d == S_LAP_RUN);
        freeze_d   = (state_d == S_LAP_RUN) || (state_d == S_LAP_PAUSE);
        // Gate on the state held during the detect cycle, not the next one.
        cnt_tick_d = tick_edge && ((state_q == S_RUN) || (state_q == S_LAP_RUN))
                     && !cnt_clr_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_clr_q  <= 1'b0;
            cnt_tick_q <= 1'b0;
            freeze_q   <= 1'b0;
            running_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_clr_q  <= cnt_clr_d;
            cnt_tick_q <= cnt_tick_d;
            freeze_q   <= freeze_d;
            running_q  <= running_d;
        end
    end

    assign cnt_tick    = cnt_tick_q;
    assign cnt_clr     = cnt_clr_q;
    assign disp_freeze = freeze_q;
    assign running     = running_q;
    assign state       = state_q;

endmodule

`default_nettype wire
